// File: rtl/matrix_multiply_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_multiply_ctrl
//  Description : Sequencer for the matrix-multiply datapath. On start it walks
//                every (i,j) element of Z = X * Y. For each element it issues
//                the X/Y RAM read addresses and multiply-accumulates the words
//                that come back. It then writes the sum to the Z RAM.
//  Ports       : clk          - clock, all state on the rising edge
//                rst_n        - asynchronous active-low reset
//                start_i      - request a full multiply (sampled in IDLE only)
//                busy_o       - high from the cycle after start through DONE
//                done_o       - one-cycle pulse in the DONE state
//                x_addr_o     - X RAM read address, i*N + k
//                y_addr_o     - Y RAM read address, k*Y_COLS + j
//                x_rd_data_i  - X RAM read data, one cycle after x_addr_o
//                y_rd_data_i  - Y RAM read data, one cycle after y_addr_o
//                z_addr_o     - Z RAM write address, i*Y_COLS + j
//                z_wen_o      - Z RAM write enable, one cycle per element
//                z_data_o     - Z RAM write data (accumulated sum)
//  Revision    : 1.0 - initial release
// ============================================================================
module matrix_multiply_ctrl #(
    parameter int ADDR_WIDTH    = 4,
    parameter int DATA_WIDTH    = 32,
    parameter int X_ROWS        = 2,
    parameter int Y_COLS        = 2,
    parameter int X_COLS_Y_ROWS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ADDR_WIDTH-1:0] x_addr_o,
    output logic [ADDR_WIDTH-1:0] y_addr_o,
    input  logic [DATA_WIDTH-1:0] x_rd_data_i,
    input  logic [DATA_WIDTH-1:0] y_rd_data_i,
    output logic [ADDR_WIDTH-1:0] z_addr_o,
    output logic                  z_wen_o,
    output logic [DATA_WIDTH-1:0] z_data_o
);

    // Counter widths; a dimension of 1 still gets a 1-bit counter.
    localparam int I_W = (X_ROWS > 1)        ? $clog2(X_ROWS)        : 1;
    localparam int J_W = (Y_COLS > 1)        ? $clog2(Y_COLS)        : 1;
    localparam int K_W = (X_COLS_Y_ROWS > 1) ? $clog2(X_COLS_Y_ROWS) : 1;

    localparam logic [I_W-1:0]        C_I_LAST = I_W'(X_ROWS - 1);
    localparam logic [J_W-1:0]        C_J_LAST = J_W'(Y_COLS - 1);
    localparam logic [K_W-1:0]        C_K_LAST = K_W'(X_COLS_Y_ROWS - 1);
    localparam logic [ADDR_WIDTH-1:0] C_N_A    = ADDR_WIDTH'(X_COLS_Y_ROWS);
    localparam logic [ADDR_WIDTH-1:0] C_YC_A   = ADDR_WIDTH'(Y_COLS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_ACC   = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                  state_q,    state_d;
    logic [I_W-1:0]          i_q,        i_d;
    logic [J_W-1:0]          j_q,        j_d;
    logic [K_W-1:0]          k_q,        k_d;
    logic [DATA_WIDTH-1:0]   acc_q,      acc_d;
    logic                    rd_valid_q, rd_valid_d;
    logic [ADDR_WIDTH-1:0]   x_addr_q,   x_addr_d;
    logic [ADDR_WIDTH-1:0]   y_addr_q,   y_addr_d;

    logic [ADDR_WIDTH-1:0]   w_x_addr;
    logic [ADDR_WIDTH-1:0]   w_y_addr;
    logic [ADDR_WIDTH-1:0]   w_z_addr;
    logic [DATA_WIDTH-1:0]   w_prod;

    assign w_x_addr = ADDR_WIDTH'(i_q) * C_N_A  + ADDR_WIDTH'(k_q);
    assign w_y_addr = ADDR_WIDTH'(k_q) * C_YC_A + ADDR_WIDTH'(j_q);
    assign w_z_addr = ADDR_WIDTH'(i_q) * C_YC_A + ADDR_WIDTH'(j_q);

    // Low DATA_WIDTH bits of the product are identical for signed and
    // unsigned operands, so a plain multiply gives two's-complement wrap.
    assign w_prod = x_rd_data_i * y_rd_data_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            i_q        <= '0;
            j_q        <= '0;
            k_q        <= '0;
            acc_q      <= '0;
            rd_valid_q <= 1'b0;
            x_addr_q   <= '0;
            y_addr_q   <= '0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            j_q        <= j_d;
            k_q        <= k_d;
            acc_q      <= acc_d;
            rd_valid_q <= rd_valid_d;
            x_addr_q   <= x_addr_d;
            y_addr_q   <= y_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        j_d        = j_q;
        k_d        = k_q;
        acc_d      = acc_q;
        x_addr_d   = x_addr_q;
        y_addr_d   = y_addr_q;
        // Sync RAM: data for a FETCH-cycle address returns one cycle later.
        rd_valid_d = (state_q == S_FETCH);

        if (rd_valid_q) begin
            acc_d = acc_q + w_prod;
        end

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_FETCH;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    acc_d   = '0;
                end
            end
            S_FETCH: begin
                x_addr_d = w_x_addr;
                y_addr_d = w_y_addr;
                if (k_q == C_K_LAST) begin
                    state_d = S_ACC;
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end
            S_ACC: begin
                // Last product lands in acc on this edge.
                state_d = S_WRITE;
            end
            S_WRITE: begin
                acc_d = '0;
                k_d   = '0;
                if (j_q == C_J_LAST) begin
                    j_d = '0;
                    if (i_q == C_I_LAST) begin
                        i_d     = '0;
                        state_d = S_DONE;
                    end else begin
                        i_d     = i_q + I_W'(1);
                        state_d = S_FETCH;
                    end
                end else begin
                    j_d     = j_q + J_W'(1);
                    state_d = S_FETCH;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy_o   = (state_q != S_IDLE);
    assign done_o   = (state_q == S_DONE);
    assign z_wen_o  = (state_q == S_WRITE);
    assign z_addr_o = (state_q == S_WRITE) ? w_z_addr : '0;
    assign z_data_o = (state_q == S_WRITE) ? acc_q    : '0;

    // Addresses are live during FETCH and hold their last value elsewhere.
    assign x_addr_o = (state_q == S_FETCH) ? w_x_addr : x_addr_q;
    assign y_addr_o = (state_q == S_FETCH) ? w_y_addr : y_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_matrix_multiply_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_matrix_multiply_ctrl
//  Description : Self-checking bench for matrix_multiply_ctrl. Two instances:
//                a 2x2x2 default build and a 3x1x1 build. Both share one pair
//                of X/Y RAM models. Results are checked against a reference
//                model built from plain nested-loop arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_multiply_ctrl;

    localparam int AW = 4;
    localparam int DW = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic sel   = 1'b0;

    always #5 clk = ~clk;

    logic          a_start, a_busy, a_done, a_zwen;
    logic [AW-1:0] a_xa, a_ya, a_za, a_xa_l, a_ya_l;
    logic [DW-1:0] a_xd, a_yd, a_zd;
    logic          b_start, b_busy, b_done, b_zwen;
    logic [AW-1:0] b_xa, b_ya, b_za, b_xa_l, b_ya_l;
    logic [DW-1:0] b_xd, b_yd, b_zd;

    assign a_start = start & ~sel;
    assign b_start = start &  sel;

    matrix_multiply_ctrl u_dut_a (
        .clk(clk), .rst_n(rst_n), .start_i(a_start), .busy_o(a_busy), .done_o(a_done),
        .x_addr_o(a_xa), .y_addr_o(a_ya), .x_rd_data_i(a_xd), .y_rd_data_i(a_yd),
        .z_addr_o(a_za), .z_wen_o(a_zwen), .z_data_o(a_zd)
    );

    matrix_multiply_ctrl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .X_ROWS(3), .Y_COLS(1), .X_COLS_Y_ROWS(1)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start_i(b_start), .busy_o(b_busy), .done_o(b_done),
        .x_addr_o(b_xa), .y_addr_o(b_ya), .x_rd_data_i(b_xd), .y_rd_data_i(b_yd),
        .z_addr_o(b_za), .z_wen_o(b_zwen), .z_data_o(b_zd)
    );

    // Synchronous RAM models: the address seen mid-cycle is read at the
    // following rising edge.
    logic [DW-1:0] xm [16];
    logic [DW-1:0] ym [16];

    always @(negedge clk) begin
        a_xa_l <= a_xa; a_ya_l <= a_ya;
        b_xa_l <= b_xa; b_ya_l <= b_ya;
    end

    always @(posedge clk) begin
        a_xd <= xm[a_xa_l]; a_yd <= ym[a_ya_l];
        b_xd <= xm[b_xa_l]; b_yd <= ym[b_ya_l];
    end

    // Signals of whichever instance is under test.
    logic          s_busy, s_done, s_zwen;
    logic [AW-1:0] s_xa, s_ya, s_za;
    logic [DW-1:0] s_zd;
    assign s_busy = sel ? b_busy : a_busy;
    assign s_done = sel ? b_done : a_done;
    assign s_zwen = sel ? b_zwen : a_zwen;
    assign s_xa   = sel ? b_xa   : a_xa;
    assign s_ya   = sel ? b_ya   : a_ya;
    assign s_za   = sel ? b_za   : a_za;
    assign s_zd   = sel ? b_zd   : a_zd;

    // Z write log.
    int            zq_a[$];
    logic [DW-1:0] zq_d[$];
    always @(negedge clk) begin
        if (s_zwen === 1'b1) begin
            zq_a.push_back(int'(s_za));
            zq_d.push_back(s_zd);
        end
    end

    int checks = 0;
    int errors = 0;
    int busy_cnt, done_cnt, done_at;
    int tr_x[$];
    int tr_y[$];

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pulse start and record one run. rep1/rep2 re-assert start on those busy
    // cycles; hold keeps start high the whole time.
    task automatic run(input int rep1, input int rep2, input bit hold);
        int guard;
        busy_cnt = 0; done_cnt = 0; done_at = 0;
        tr_x.delete(); tr_y.delete(); zq_a.delete(); zq_d.delete();
        start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        guard = 0;
        while (guard < 300) begin
            guard++;
            if (s_busy !== 1'b1) break;
            busy_cnt++;
            tr_x.push_back(int'(s_xa));
            tr_y.push_back(int'(s_ya));
            if (s_done === 1'b1) begin
                done_cnt++;
                done_at = busy_cnt;
            end
            if (busy_cnt == rep1 || busy_cnt == rep2) start = 1'b1;
            else if (!hold)                           start = 1'b0;
            @(negedge clk);
        end
        check("run_terminates", DW'(guard < 300), DW'(1));
    endtask

    // Compare the recorded run against a nested-loop reference model.
    task automatic verify(input int r, input int c, input int n, input string tag);
        logic [DW-1:0] acc;
        int ex[$];
        int ey[$];
        int len;
        len = r * c * (n + 2) + 1;
        check({tag, "_busy_len"}, DW'(busy_cnt), DW'(len));
        check({tag, "_done_cnt"}, DW'(done_cnt), DW'(1));
        check({tag, "_done_pos"}, DW'(done_at),  DW'(len));
        check({tag, "_zw_cnt"},   DW'(zq_a.size()), DW'(r * c));
        for (int e = 0; e < r * c && e < zq_a.size(); e++) begin
            acc = '0;
            for (int k = 0; k < n; k++)
                acc = acc + xm[(e / c) * n + k] * ym[k * c + (e % c)];
            check({tag, "_z_addr"}, DW'(zq_a[e]), DW'(e));
            check({tag, "_z_data"}, zq_d[e], acc);
        end
        for (int i = 0; i < r; i++)
            for (int j = 0; j < c; j++) begin
                for (int k = 0; k < n; k++) begin
                    ex.push_back(i * n + k);
                    ey.push_back(k * c + j);
                end
                ex.push_back(ex[$]); ey.push_back(ey[$]);
                ex.push_back(ex[$]); ey.push_back(ey[$]);
            end
        ex.push_back(ex[$]); ey.push_back(ey[$]);
        check({tag, "_trace_len"}, DW'(tr_x.size()), DW'(ex.size()));
        for (int t = 0; t < ex.size() && t < tr_x.size(); t++) begin
            check({tag, "_x_addr"}, DW'(tr_x[t]), DW'(ex[t]));
            check({tag, "_y_addr"}, DW'(tr_y[t]), DW'(ey[t]));
        end
    endtask

    task automatic load_test1();
        xm[0] = 1; xm[1] = 2; xm[2] = 3; xm[3] = 4;
        ym[0] = 5; ym[1] = 6; ym[2] = 7; ym[3] = 8;
    endtask

    initial begin
        int n;
        int g;
        for (int a = 0; a < 16; a++) begin xm[a] = '0; ym[a] = '0; end

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy",   DW'(a_busy), DW'(0));
        check("rst_done",   DW'(a_done), DW'(0));
        check("rst_zwen",   DW'(a_zwen), DW'(0));
        check("rst_xaddr",  DW'(a_xa),   DW'(0));
        check("rst_yaddr",  DW'(a_ya),   DW'(0));
        check("rst_zaddr",  DW'(a_za),   DW'(0));
        check("rst_zdata",  a_zd,        DW'(0));
        check("rst_b_busy", DW'(b_busy), DW'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_no_start", DW'(a_busy), DW'(0));

        // Known 2x2 product
        load_test1();
        run(0, 0, 1'b0);
        verify(2, 2, 2, "t1");
        if (zq_d.size() == 4) begin
            check("t1_z0", zq_d[0], DW'(19));
            check("t1_z1", zq_d[1], DW'(22));
            check("t1_z2", zq_d[2], DW'(43));
            check("t1_z3", zq_d[3], DW'(50));
        end else check("t1_zcount", DW'(zq_d.size()), DW'(4));
        @(negedge clk);

        // Wrap-around arithmetic
        for (int a = 0; a < 4; a++) begin xm[a] = 32'hFFFF_FFFF; ym[a] = 32'd3; end
        run(0, 0, 1'b0);
        verify(2, 2, 2, "neg");
        for (int e = 0; e < zq_d.size(); e++) check("neg_const", zq_d[e], 32'hFFFF_FFFA);
        for (int a = 0; a < 4; a++) begin xm[a] = 32'h8000_0000; ym[a] = 32'd2; end
        run(0, 0, 1'b0);
        verify(2, 2, 2, "wrap");
        for (int e = 0; e < zq_d.size(); e++) check("wrap_const", zq_d[e], 32'h0);
        @(negedge clk);

        // start while busy is ignored
        load_test1();
        run(3, 10, 1'b0);
        verify(2, 2, 2, "repulse");
        check("repulse_idle", DW'(s_busy), DW'(0));
        @(negedge clk);
        check("repulse_no_restart", DW'(s_busy), DW'(0));

        // start held through DONE: back-to-back run
        run(0, 0, 1'b1);
        verify(2, 2, 2, "hold");
        @(negedge clk);
        check("b2b_restart", DW'(s_busy), DW'(1));
        start = 1'b0;
        n = 1; g = 0;
        do begin
            @(negedge clk);
            g++;
            if (s_busy === 1'b1) n++;
        end while (s_busy === 1'b1 && g < 100);
        check("b2b_len", DW'(n), DW'(17));
        @(negedge clk);

        // Asynchronous reset mid-element 1
        zq_a.delete(); zq_d.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", DW'(a_busy), DW'(0));
        check("arst_done", DW'(a_done), DW'(0));
        check("arst_zwen", DW'(a_zwen), DW'(0));
        @(negedge clk);
        check("arst_zcount", DW'(zq_a.size()), DW'(1));
        if (zq_a.size() >= 1) begin
            check("arst_z0_addr", DW'(zq_a[0]), DW'(0));
            check("arst_z0_data", zq_d[0], DW'(19));
        end
        rst_n = 1'b1;
        @(negedge clk);
        run(0, 0, 1'b0);
        verify(2, 2, 2, "after_rst");
        @(negedge clk);

        // Randomized operands
        for (int r = 0; r < 4; r++) begin
            for (int a = 0; a < 4; a++) begin
                xm[a] = (r < 2) ? $urandom : DW'($urandom_range(0, 40)) - DW'(20);
                ym[a] = (r < 2) ? $urandom : DW'($urandom_range(0, 40)) - DW'(20);
            end
            run(0, 0, 1'b0);
            verify(2, 2, 2, "rand");
            @(negedge clk);
        end

        // 3x1 by 1x1 build, N == 1
        sel = 1'b1;
        xm[0] = 2; xm[1] = 3; xm[2] = 4; ym[0] = 5;
        run(0, 0, 1'b0);
        verify(3, 1, 1, "small");
        if (zq_d.size() == 3) begin
            check("small_z0", zq_d[0], DW'(10));
            check("small_z1", zq_d[1], DW'(15));
            check("small_z2", zq_d[2], DW'(20));
        end else check("small_zcount", DW'(zq_d.size()), DW'(3));
        @(negedge clk);
        for (int a = 0; a < 3; a++) xm[a] = $urandom;
        ym[0] = $urandom;
        run(0, 0, 1'b0);
        verify(3, 1, 1, "small_rand");
        check("a_stays_idle", DW'(a_busy), DW'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global bound on simulation time.
    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
